// File: rtl/cdc_src_arbiter.sv
// Round-robin arbiter that feeds a single CDC source port from NumIn requesters.
// Define CDC_SRC_ARB_FLUSH_EN to build the flush FSM (IDLE/DRAIN/CLEAR/DONE), cdc_clr_o and flush_done_o.
module cdc_src_arbiter #(
  parameter int NumIn        = 4,
  parameter int DataWidth    = 32,
  parameter int ClrCycles    = 2,
  parameter int DrainTimeout = 0,
  localparam int IdxWidth    = $clog2(NumIn)
) (
  input  logic                          clk_i,
  input  logic                          rst_ni,
  input  logic [NumIn-1:0]              req_valid_i,
  input  logic [NumIn*DataWidth-1:0]    req_data_i,
  output logic [NumIn-1:0]              req_ready_o,
  output logic                          cdc_valid_o,
  output logic [IdxWidth+DataWidth-1:0] cdc_data_o,
  input  logic                          cdc_ready_i,
  input  logic                          flush_i,
  output logic                          cdc_clr_o,
  output logic                          flush_done_o,
  output logic                          busy_o
);

  logic [IdxWidth-1:0]  rr_r;
  logic [IdxWidth-1:0]  gnt_idx_r;
  logic                 lock_r;
  logic [IdxWidth-1:0]  arb_idx_s;
  logic                 arb_found_s;
  logic [IdxWidth:0]    sum_s;
  logic [NumIn-1:0]     req_rot_s;
  logic [NumIn-1:0]     rot_unused_s;
  logic [IdxWidth-1:0]  grant_idx_s;
  logic [IdxWidth-1:0]  rr_next_s;
  logic                 grant_act_s;
  logic                 grant_req_s;
  logic                 transfer_s;
  logic [DataWidth-1:0] grant_data_s;
  logic [NumIn-1:0]     ready_s;
  logic                 allow_new_s;
  logic                 allow_held_s;
  logic                 force_unlock_s;
  logic                 fsm_busy_s;
  logic                 clr_s;
  logic                 done_s;

  // Rotate requests so bit 0 is the requester at the round-robin pointer.
  assign {rot_unused_s, req_rot_s} = {req_valid_i, req_valid_i} >> rr_r;

  // Pick the first valid requester at or after the pointer, wrapping modulo NumIn.
  always_comb begin
    arb_found_s = 1'b0;
    arb_idx_s   = '0;
    sum_s       = '0;
    for (int k = NumIn - 1; k >= 0; k--) begin
      if (req_rot_s[k]) begin
        sum_s       = {1'b0, rr_r} + (IdxWidth+1)'(k);
        arb_found_s = 1'b1;
        if (sum_s >= (IdxWidth+1)'(NumIn)) begin
          arb_idx_s = IdxWidth'(sum_s - (IdxWidth+1)'(NumIn));
        end else begin
          arb_idx_s = IdxWidth'(sum_s);
        end
      end else begin
        arb_found_s = arb_found_s;
      end
    end
  end

  assign grant_idx_s = lock_r ? gnt_idx_r : arb_idx_s;
  assign grant_act_s = rst_ni & (lock_r ? allow_held_s : (arb_found_s & allow_new_s));
  assign rr_next_s   = (grant_idx_s == IdxWidth'(NumIn - 1)) ? '0 : grant_idx_s + IdxWidth'(1);

  // Payload mux and one-hot ready for the granted requester.
  always_comb begin
    grant_data_s = '0;
    grant_req_s  = 1'b0;
    ready_s      = '0;
    for (int i = 0; i < NumIn; i++) begin
      if (grant_idx_s == IdxWidth'(i)) begin
        grant_data_s = req_data_i[i*DataWidth +: DataWidth];
        grant_req_s  = req_valid_i[i];
        ready_s[i]   = grant_act_s & cdc_ready_i;
      end else begin
        ready_s[i] = 1'b0;
      end
    end
  end

  assign transfer_s  = grant_act_s & cdc_ready_i & grant_req_s;
  assign cdc_valid_o = grant_act_s;
  assign cdc_data_o  = {grant_idx_s, grant_data_s};
  assign req_ready_o = ready_s;

  // Grant lock, held index and round-robin pointer.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      lock_r    <= 1'b0;
      gnt_idx_r <= '0;
      rr_r      <= '0;
    end else if (transfer_s) begin
      lock_r <= 1'b0;
      rr_r   <= rr_next_s;
    end else if (force_unlock_s) begin
      lock_r <= 1'b0;
    end else if (grant_act_s && !lock_r && !cdc_ready_i) begin
      lock_r    <= 1'b1;
      gnt_idx_r <= arb_idx_s;
    end else begin
      lock_r <= lock_r;
    end
  end

`ifdef CDC_SRC_ARB_FLUSH_EN
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DRAIN = 2'd1,
    ST_CLEAR = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  state_e      state_r;
  state_e      state_s;
  logic [15:0] drain_cnt_r;
  logic [3:0]  clr_cnt_r;
  logic        timeout_s;

  // Flush FSM state and the DRAIN/CLEAR cycle counters.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_r     <= ST_IDLE;
      drain_cnt_r <= 16'd0;
      clr_cnt_r   <= 4'd0;
    end else begin
      state_r     <= state_s;
      drain_cnt_r <= (state_r == ST_DRAIN) ? drain_cnt_r + 16'd1 : 16'd0;
      clr_cnt_r   <= (state_r == ST_CLEAR) ? clr_cnt_r + 4'd1 : 4'd0;
    end
  end

  // Next state; a flush seen in IDLE blocks fresh grants in that same cycle.
  always_comb begin
    state_s      = state_r;
    allow_new_s  = 1'b0;
    allow_held_s = 1'b0;
    timeout_s    = 1'b0;
    case (state_r)
      ST_IDLE: begin
        allow_new_s  = ~flush_i;
        allow_held_s = 1'b1;
        if (flush_i) begin
          state_s = ST_DRAIN;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_DRAIN: begin
        allow_held_s = 1'b1;
        timeout_s    = (DrainTimeout > 0) && (drain_cnt_r == 16'(DrainTimeout - 1));
        if (!lock_r || timeout_s) begin
          state_s = ST_CLEAR;
        end else begin
          state_s = ST_DRAIN;
        end
      end
      ST_CLEAR: begin
        if (clr_cnt_r == 4'(ClrCycles - 1)) begin
          state_s = ST_DONE;
        end else begin
          state_s = ST_CLEAR;
        end
      end
      ST_DONE:  state_s = ST_IDLE;
      default:  state_s = ST_IDLE;
    endcase
  end

  assign force_unlock_s = timeout_s & lock_r;
  assign fsm_busy_s     = (state_r != ST_IDLE);
  assign clr_s          = (state_r == ST_CLEAR);
  assign done_s         = (state_r == ST_DONE);
`else
  logic unused_flush_s;
  logic unused_cfg_s;

  assign unused_flush_s = flush_i;
  assign unused_cfg_s   = (ClrCycles == 0) ^ (DrainTimeout == 0);
  assign allow_new_s    = 1'b1;
  assign allow_held_s   = 1'b1;
  assign force_unlock_s = 1'b0;
  assign fsm_busy_s     = 1'b0;
  assign clr_s          = 1'b0;
  assign done_s         = 1'b0;
`endif

  assign cdc_clr_o    = clr_s;
  assign flush_done_o = done_s;
  assign busy_o       = fsm_busy_s | lock_r;

endmodule
